// File: rtl/rr_access_arbiter_pkg.sv
// Shared types and helpers for the round-robin access arbiter.
// The watchdog counter width is derived here from TIMEOUT.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } arb_state_e;

    // A zero-width counter is illegal, so a disabled watchdog still gets one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_access_arbiter_if.sv
// Requester and target handshake bundle between the agents and the arbiter.
// The agents drive through master; the arbiter connects through slave.
interface rr_access_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req_i;
    logic [N-1:0] we_i;
    logic [N-1:0] gnt_o;
    logic [N-1:0] done_o;
    logic [N-1:0] err_o;
    logic         t_req;
    logic         t_we;
    logic         t_idle;
    logic         t_ack;

    modport master (
        output req_i, we_i, t_idle, t_ack,
        input  gnt_o, done_o, err_o, t_req, t_we
    );

    modport slave (
        input  req_i, we_i, t_idle, t_ack,
        output gnt_o, done_o, err_o, t_req, t_we
    );
endinterface

// File: rtl/rr_access_arbiter_rr_pick.sv
// Combinational round-robin picker.
// It returns the first set request scanning upward from i_ptr+1, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_hot,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);
    int w_j;

    always_comb begin
        o_hot = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = 0;
        for (int i = 1; i <= N; i++) begin
            w_j = (int'(i_ptr) + i) % N;
            if (!o_vld && i_req[w_j[IW-1:0]]) begin
                o_vld               = 1'b1;
                o_idx               = w_j[IW-1:0];
                o_hot[w_j[IW-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_access_arbiter.sv
// Shares one req/we/ack target among N requesters with round-robin grants.
// Only one transaction is in flight at a time, and a watchdog aborts hung transactions.
module rr_access_arbiter
    import arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 16,
    localparam int CNT_W   = cnt_width(TIMEOUT),
    localparam int IW      = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 resetn,
    rr_access_arbiter_if.slave   bus
);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_idx;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     r_done;
    logic [N-1:0]     r_err;
    logic             r_treq;
    logic             r_twe;

    logic [N-1:0]     w_hot;
    logic [IW-1:0]    w_idx;
    logic             w_vld;
    logic             w_expire;

    rr_pick #(.N(N)) u_pick (
        .i_req (bus.req_i),
        .i_ptr (r_ptr),
        .o_hot (w_hot),
        .o_idx (w_idx),
        .o_vld (w_vld)
    );

    assign w_expire = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ARB;
            r_ptr   <= IW'(N - 1);
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_treq  <= 1'b0;
            r_twe   <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            unique case (r_state)
                ARB: begin
                    // A target that is not idle (for example, hung after an abort) blocks all grants.
                    if (w_vld && bus.t_idle) begin
                        r_idx   <= w_idx;
                        r_we    <= bus.we_i[w_idx];
                        r_gnt   <= w_hot;
                        r_state <= ISSUE;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                ISSUE: begin
                    r_treq  <= 1'b1;
                    r_twe   <= r_we;
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_treq <= 1'b0;
                    if (bus.t_ack || w_expire) begin
                        // If ack and expiry coincide, the ack takes priority.
                        if (bus.t_ack) r_done[r_idx] <= 1'b1;
                        else           r_err[r_idx]  <= 1'b1;
                        r_gnt   <= '0;
                        r_ptr   <= r_idx;
                        r_twe   <= 1'b0;
                        r_state <= ARB;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign bus.gnt_o  = r_gnt;
    assign bus.done_o = r_done;
    assign bus.err_o  = r_err;
    assign bus.t_req  = r_treq;
    assign bus.t_we   = r_twe;
endmodule

// File: tb/tb_rr_access_arbiter.sv
// Directed bench for rr_access_arbiter.
// A transaction-level model predicts every output each cycle, and literal checks pin the model.
module tb_rr_access_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    bit   chk_en = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    rr_access_arbiter_if #(.N(N)) bus();

    rr_access_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model: an owner that is busy for an age counted in cycles since the grant.
    int           m_last  = N - 1;
    bit           m_busy  = 1'b0;
    int           m_owner = 0;
    int           m_age   = 0;
    bit           m_we    = 1'b0;
    logic [N-1:0] e_gnt   = '0;
    logic [N-1:0] e_done  = '0;
    logic [N-1:0] e_err   = '0;
    logic         e_treq  = 1'b0;
    logic         e_twe   = 1'b0;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_last = N - 1; m_busy = 1'b0; m_owner = 0; m_age = 0; m_we = 1'b0;
            e_gnt = '0; e_done = '0; e_err = '0; e_treq = 1'b0; e_twe = 1'b0;
        end else begin
            e_done = '0;
            e_err  = '0;
            e_treq = 1'b0;
            if (!m_busy) begin
                if (bus.req_i != '0 && bus.t_idle) begin
                    for (int i = 1; i <= N; i++) begin
                        int c;
                        c = (m_last + i) % N;
                        if (!m_busy && bus.req_i[c]) begin
                            m_busy = 1'b1; m_owner = c; m_we = bus.we_i[c]; m_age = 0;
                        end
                    end
                    e_gnt = '0;
                    e_gnt[m_owner] = 1'b1;
                end
            end else if (m_age == 0) begin
                m_age  = 1;
                e_treq = 1'b1;
                e_twe  = m_we;
            end else if (bus.t_ack || m_age == TO) begin
                if (bus.t_ack) e_done[m_owner] = 1'b1;
                else           e_err[m_owner]  = 1'b1;
                e_gnt  = '0;
                m_busy = 1'b0;
                m_last = m_owner;
            end else begin
                m_age++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt_o", 32'(bus.gnt_o), 32'(e_gnt));
            chk("done_o", 32'(bus.done_o), 32'(e_done));
            chk("err_o", 32'(bus.err_o), 32'(e_err));
            chk("t_req", 32'(bus.t_req), 32'(e_treq));
            if (e_treq) chk("t_we", 32'(bus.t_we), 32'(e_twe));
            chk("onehot_inv", 32'($onehot0(bus.gnt_o) && $onehot0(bus.done_o) &&
                $onehot0(bus.err_o) && ((bus.done_o & bus.err_o) == '0)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_treq();
        int n = 0;
        while (!bus.t_req && n < 50) begin
            tick();
            n++;
        end
        if (!bus.t_req) chk("treq_wait", 32'(bus.t_req), 32'd1);
    endtask

    // After the cycle in which t_req is seen, wait d cycles, then present ack for one edge.
    task automatic ack_after(input int d);
        repeat (d) tick();
        bus.t_ack = 1'b1;
        tick();
        bus.t_ack = 1'b0;
    endtask

    function automatic int hot2idx(input logic [N-1:0] h);
        for (int i = 0; i < N; i++) if (h[i]) return i;
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int got[5];
        int exp_ord[5];
        int n;
        int seen;
        exp_ord = '{0, 1, 2, 3, 0};
        bus.req_i = '0; bus.we_i = '0; bus.t_idle = 1'b1; bus.t_ack = 1'b0;
        #2 resetn = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        resetn = 1'b1;
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_treq", 32'(bus.t_req), 32'd0);
        chk("rst_twe", 32'(bus.t_we), 32'd0);

        // Single write from requester 0, acknowledged 3 cycles after t_req.
        bus.req_i = 4'b0001; bus.we_i = 4'b0001;
        wait_treq();
        chk("t1_gnt", 32'(bus.gnt_o), 32'b0001);
        chk("t1_twe", 32'(bus.t_we), 32'd1);
        ack_after(3);
        chk("t1_done", 32'(bus.done_o), 32'b0001);
        chk("t1_gnt_off", 32'(bus.gnt_o), 32'd0);
        bus.req_i = '0;
        tick();
        chk("t1_done_once", 32'(bus.done_o), 32'd0);

        // All four requesters held; grants must rotate 0,1,2,3,0.
        apply_reset();
        bus.req_i = 4'b1111; bus.we_i = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            wait_treq();
            got[k] = hot2idx(bus.gnt_o);
            ack_after(1);
        end
        bus.req_i = '0;
        for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), 32'(got[k]), 32'(exp_ord[k]));
        for (int k = 1; k < 5; k++) chk($sformatf("t2_norepeat%0d", k), 32'(got[k] != got[k-1]), 32'd1);
        tick();

        // No ack: the watchdog fires 16 cycles into WAIT, and a busy target blocks further issues.
        apply_reset();
        bus.req_i = 4'b0100; bus.we_i = 4'b0000;
        wait_treq();
        n = 0;
        while (bus.err_o == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("t3_err_lat", 32'(n), 32'd16);
        chk("t3_err", 32'(bus.err_o), 32'b0100);
        chk("t3_nodone", 32'(bus.done_o), 32'd0);
        bus.t_idle = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.t_req || bus.gnt_o != '0) seen++;
        end
        chk("t3_blocked", 32'(seen), 32'd0);
        bus.t_idle = 1'b1;
        bus.req_i  = '0;
        tick();

        // An ack on the last watchdog cycle wins over the timeout.
        apply_reset();
        bus.req_i = 4'b0001; bus.we_i = 4'b0000;
        wait_treq();
        ack_after(15);
        chk("t4_done", 32'(bus.done_o), 32'b0001);
        chk("t4_noerr", 32'(bus.err_o), 32'd0);
        bus.req_i = '0;
        tick();

        // Requester 1 drops its request after the grant; the transaction still completes.
        bus.req_i = 4'b0010; bus.we_i = 4'b0010;
        wait_treq();
        chk("t5_gnt", 32'(bus.gnt_o), 32'b0010);
        bus.req_i = '0;
        ack_after(2);
        chk("t5_done", 32'(bus.done_o), 32'b0010);
        tick();

        // Reset during WAIT clears outputs immediately; requester 0 is first afterwards.
        bus.req_i = 4'b0011; bus.we_i = 4'b0000;
        wait_treq();
        tick();
        #2 resetn = 1'b0;
        #1;
        chk("t6_gnt", 32'(bus.gnt_o), 32'd0);
        chk("t6_treq", 32'(bus.t_req), 32'd0);
        chk("t6_done", 32'(bus.done_o), 32'd0);
        chk("t6_err", 32'(bus.err_o), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        wait_treq();
        chk("t6_prio0", 32'(bus.gnt_o), 32'b0001);
        ack_after(1);
        bus.req_i = '0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
